// File: rtl/generic_pkg.sv
// Shared types and helpers for the serializer blocks.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package generic_pkg;

    // Serializer control states: waiting for a word, or shifting one out.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Counter width able to index n items; never collapses to zero bits.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/x_in_to_single_out.sv
// Parallel-to-serial: accepts a NUM_INS-bit word, emits it one bit per accepted beat.
// Latency: word accepted at edge k -> first bit valid in cycle k+1; full rate back-to-back.
// Backpressure: out_ready low freezes out_bit/out_valid; in_ready only rises in IDLE or on a consumed last bit.

// Register with synchronous active-high reset to a fixed value.
`ifndef REG_DECL_DEFINED
`define REG_DECL_DEFINED
`define REG_DECL(q, rstval, d) \
    always_ff @(posedge clk) begin \
        if (rst) q <= rstval; \
        else     q <= d; \
    end
`endif

module x_in_to_single_out
    import generic_pkg::*;
#(
    parameter int NUM_INS   = 8,
    parameter bit LSB_FIRST = 1'b1,
    parameter bit IDLE_VAL  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_INS-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_bit,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_first,
    output logic               out_last
);

    localparam int             CW       = cnt_w(NUM_INS);
    localparam logic [CW-1:0]  CNT_LAST = CW'(NUM_INS - 1);

    ser_state_t         state;
    ser_state_t         state_nxt;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_nxt;
    logic [NUM_INS-1:0] word;
    logic [NUM_INS-1:0] word_nxt;
    logic [CW-1:0]      bit_idx;

    logic shifting;
    logic at_last;
    logic word_done;
    logic load;

    assign shifting  = (state == SHIFT);
    assign at_last   = shifting && (cnt == CNT_LAST);
    // The sink taking the last bit frees the word register this very cycle,
    // which is what lets the next word load without a bubble.
    assign word_done = at_last && out_ready;
    assign in_ready  = !shifting || word_done;
    assign load      = in_valid && in_ready;

    // Next-state, counter and word-register update rules.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        word_nxt  = word;
        if (load) begin
            state_nxt = SHIFT;
            cnt_nxt   = '0;
            word_nxt  = in_data;
        end else if (word_done) begin
            state_nxt = IDLE;
        end else if (shifting && out_ready) begin
            cnt_nxt   = cnt + 1'b1;
        end
    end

    // FSM state register.
    `REG_DECL(state, IDLE, state_nxt)

    // Bit counter; stays within 0..NUM_INS-1 and restarts only on load.
    `REG_DECL(cnt, '0, cnt_nxt)

    // Captured word; later in_data changes do not disturb it.
    `REG_DECL(word, '0, word_nxt)

    // cnt never exceeds CNT_LAST, so the mirrored index stays in range.
    assign bit_idx   = LSB_FIRST ? cnt : (CNT_LAST - cnt);

    assign out_valid = shifting;
    assign out_bit   = shifting ? word[bit_idx] : IDLE_VAL;
    assign out_first = shifting && (cnt == '0);
    assign out_last  = at_last;

endmodule
